// File: rtl/ps2_keyboard_controller_if.sv
// Keyboard-side bundle of the PS/2 controller: raw PS/2 lines in, Hack key code
// and frame-error pulse out. The controller sits on the slave side.
interface ps2_keyboard_controller_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] kb_out;
    logic        frame_err;

    modport master (output ps2_clk, output ps2_data, input kb_out, input frame_err);
    modport slave  (input ps2_clk, input ps2_data, output kb_out, output frame_err);
endinterface

// File: rtl/ps2_keyboard_controller.sv
// PS/2 scancode set 2 receiver and decoder producing the Hack keyboard word
// (code of the most recently pressed, still-held key, 0 when none is held).
module ps2_keyboard_controller #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic                      clk,
    input logic                      reset,
    ps2_keyboard_controller_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] LETTER_CODES [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGIT_CODES [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    localparam logic [7:0] FKEY_CODES [12] = '{
        8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
    localparam logic [7:0] EXT_CODES [10] = '{
        8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};

    // bit 0 = ps2_clk, bit 1 = ps2_data
    logic [1:0]       w_ps2_in;
    logic [1:0]       r_meta;
    logic [1:0]       r_sync;
    logic             r_clk_prev;
    logic             w_fall;
    logic             w_bit;

    state_t           r_state;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_parity_ok;
    logic [CNT_W-1:0] r_idle_cnt;
    logic             r_frame_err;
    logic             r_deliver;

    logic             r_ext;
    logic             r_brk;
    logic [8:0]       r_held;
    logic [15:0]      r_kb_out;
    logic [8:0]       w_id;
    logic             w_hit;
    logic [15:0]      w_code;

    assign w_ps2_in = {bus.ps2_data, bus.ps2_clk};
    assign w_fall   = r_clk_prev & ~r_sync[0];
    assign w_bit    = r_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta     <= 2'b11;
            r_sync     <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_meta     <= w_ps2_in;
            r_sync     <= r_meta;
            r_clk_prev <= r_sync[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_parity_ok <= 1'b0;
            r_idle_cnt  <= '0;
            r_frame_err <= 1'b0;
            r_deliver   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_deliver   <= 1'b0;
            if (w_fall) begin
                r_idle_cnt <= '0;
                case (r_state)
                    IDLE: begin
                        if (!w_bit) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= PARITY;
                    end
                    PARITY: begin
                        r_parity_ok <= ^{w_bit, r_shift};
                        r_state     <= STOP;
                    end
                    STOP: begin
                        // r_shift stays stable in IDLE, so the decoder reads the byte from it
                        if (w_bit && r_parity_ok)
                            r_deliver <= 1'b1;
                        else
                            r_frame_err <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE) begin
                if (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    r_state     <= IDLE;
                    r_idle_cnt  <= '0;
                    r_bit_cnt   <= '0;
                    r_shift     <= '0;
                    r_frame_err <= 1'b1;
                end else if (r_idle_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
                    r_idle_cnt <= r_idle_cnt + CNT_W'(1);
                end
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

    assign w_id = {r_ext, r_shift};

    always_comb begin
        w_hit  = 1'b0;
        w_code = '0;
        if (!r_ext) begin
            for (int i = 0; i < 26; i++)
                if (r_shift == LETTER_CODES[i]) begin
                    w_hit  = 1'b1;
                    w_code = 16'(65 + i);
                end
            for (int i = 0; i < 10; i++)
                if (r_shift == DIGIT_CODES[i]) begin
                    w_hit  = 1'b1;
                    w_code = 16'(48 + i);
                end
            for (int i = 0; i < 12; i++)
                if (r_shift == FKEY_CODES[i]) begin
                    w_hit  = 1'b1;
                    w_code = 16'(141 + i);
                end
            case (r_shift)
                8'h29: begin w_hit = 1'b1; w_code = 16'd32;  end
                8'h5A: begin w_hit = 1'b1; w_code = 16'd128; end
                8'h66: begin w_hit = 1'b1; w_code = 16'd129; end
                8'h76: begin w_hit = 1'b1; w_code = 16'd140; end
                default: ;
            endcase
        end else begin
            for (int i = 0; i < 10; i++)
                if (r_shift == EXT_CODES[i]) begin
                    w_hit  = 1'b1;
                    w_code = 16'(130 + i);
                end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ext    <= 1'b0;
            r_brk    <= 1'b0;
            r_held   <= '0;
            r_kb_out <= '0;
        end else if (r_frame_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_deliver) begin
            if (r_shift == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_shift == 8'hF0) begin
                r_brk <= 1'b1;
            end else begin
                if (w_hit) begin
                    if (!r_brk) begin
                        r_kb_out <= w_code;
                        r_held   <= w_id;
                    end else if (r_held == w_id) begin
                        // releasing a key other than the held one must not clear it
                        r_kb_out <= '0;
                        r_held   <= '0;
                    end
                end
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    assign bus.kb_out    = r_kb_out;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_ps2_keyboard_controller.sv
// Directed bench for ps2_keyboard_controller: frame table plus timeout and
// asynchronous-reset sequences, with cycle-exact latency checks.
module tb_ps2_keyboard_controller;
    localparam int T = 1000;
    localparam int H = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    ps2_keyboard_controller_if bus();

    ps2_keyboard_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int err_pulses = 0;
    int err_run = 0;
    int max_run = 0;
    int err_rise_cyc = -1;
    int kb_chg_cyc = -1;
    logic [15:0] kb_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_err) begin
            err_pulses++;
            err_run++;
            if (err_run > max_run) max_run = err_run;
            if (err_run == 1) err_rise_cyc = cyc;
        end else begin
            err_run = 0;
        end
        if (bus.kb_out != kb_prev) begin
            kb_chg_cyc = cyc;
            kb_prev    = bus.kb_out;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.ps2_data = b;
        repeat (H / 2) @(negedge clk);
        bus.ps2_clk   = 1'b0;
        last_fall_cyc = cyc;
        repeat (H) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (H / 2) @(negedge clk);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bits = frame_bits(d, bad_par, bad_stop);
        for (int b = 0; b < 11; b++) send_bit(bits[b]);
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          bad_par;
        bit          bad_stop;
        logic [15:0] exp_kb;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int e0;
        logic [15:0] prev_exp;
        logic [10:0] rbits;

        vecs.push_back('{8'h1C, 0, 0, 16'd65,  0});
        vecs.push_back('{8'hF0, 0, 0, 16'd65,  0});
        vecs.push_back('{8'h1C, 0, 0, 16'd0,   0});
        vecs.push_back('{8'hE0, 0, 0, 16'd0,   0});
        vecs.push_back('{8'h75, 0, 0, 16'd131, 0});
        vecs.push_back('{8'hE0, 0, 0, 16'd131, 0});
        vecs.push_back('{8'hF0, 0, 0, 16'd131, 0});
        vecs.push_back('{8'h75, 0, 0, 16'd0,   0});
        vecs.push_back('{8'h75, 0, 0, 16'd0,   0});
        vecs.push_back('{8'h1C, 0, 0, 16'd65,  0});
        vecs.push_back('{8'h32, 0, 0, 16'd66,  0});
        vecs.push_back('{8'hF0, 0, 0, 16'd66,  0});
        vecs.push_back('{8'h1C, 0, 0, 16'd66,  0});
        vecs.push_back('{8'hF0, 0, 0, 16'd66,  0});
        vecs.push_back('{8'h32, 0, 0, 16'd0,   0});
        vecs.push_back('{8'h1C, 1, 0, 16'd0,   1});
        vecs.push_back('{8'h1C, 0, 0, 16'd65,  0});
        vecs.push_back('{8'h12, 0, 0, 16'd65,  0});
        vecs.push_back('{8'hF0, 0, 0, 16'd65,  0});
        vecs.push_back('{8'h1C, 0, 0, 16'd0,   0});
        vecs.push_back('{8'h29, 0, 1, 16'd0,   1});
        vecs.push_back('{8'h29, 0, 0, 16'd32,  0});
        vecs.push_back('{8'hF0, 0, 0, 16'd32,  0});
        vecs.push_back('{8'h29, 0, 0, 16'd0,   0});
        vecs.push_back('{8'h5A, 0, 0, 16'd128, 0});
        vecs.push_back('{8'h45, 0, 0, 16'd48,  0});
        vecs.push_back('{8'h05, 0, 0, 16'd141, 0});
        vecs.push_back('{8'h07, 0, 0, 16'd152, 0});
        vecs.push_back('{8'h1A, 0, 0, 16'd90,  0});
        vecs.push_back('{8'hF0, 0, 1, 16'd90,  1});
        vecs.push_back('{8'h1A, 0, 0, 16'd90,  0});
        vecs.push_back('{8'h6B, 0, 0, 16'd90,  0});
        vecs.push_back('{8'hE0, 0, 0, 16'd90,  0});
        vecs.push_back('{8'h71, 0, 0, 16'd139, 0});

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("reset kb_out", int'(bus.kb_out), 0);
        check("reset frame_err", int'(bus.frame_err), 0);

        prev_exp = '0;
        foreach (vecs[i]) begin
            e0 = err_pulses;
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
            $display("[TB] vec %0d byte %02h par_bad %0d stop_bad %0d -> kb_out %0d err %0d",
                     i, vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, bus.kb_out, err_pulses - e0);
            check($sformatf("vec%0d kb_out", i), int'(bus.kb_out), int'(vecs[i].exp_kb));
            check($sformatf("vec%0d frame_err count", i), err_pulses - e0, int'(vecs[i].exp_err));
            if (vecs[i].exp_kb != prev_exp)
                check($sformatf("vec%0d kb latency", i), kb_chg_cyc - last_fall_cyc, 4);
            if (vecs[i].exp_err)
                check($sformatf("vec%0d err latency", i), err_rise_cyc - last_fall_cyc, 3);
            prev_exp = vecs[i].exp_kb;
        end

        // partial frame then silence: timeout pulse at an exact cycle
        e0 = err_pulses;
        rbits = frame_bits(8'h29, 0, 0);
        for (int b = 0; b < 6; b++) send_bit(rbits[b]);
        repeat (T + 20) @(negedge clk);
        $display("[TB] timeout: err %0d at +%0d cycles", err_pulses - e0, err_rise_cyc - last_fall_cyc);
        check("timeout err count", err_pulses - e0, 1);
        check("timeout err latency", err_rise_cyc - last_fall_cyc, T + 3);
        check("timeout kb_out", int'(bus.kb_out), 139);
        send_frame(8'h29, 0, 0);
        $display("[TB] after timeout 29 -> kb_out %0d", bus.kb_out);
        check("post-timeout 29", int'(bus.kb_out), 32);
        send_frame(8'h1C, 0, 0);
        $display("[TB] 1C -> kb_out %0d", bus.kb_out);
        check("pre-reset 1C", int'(bus.kb_out), 65);

        // asynchronous reset in the middle of a 0x16 frame
        rbits = frame_bits(8'h16, 0, 0);
        for (int b = 0; b < 4; b++) send_bit(rbits[b]);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        $display("[TB] async reset mid-frame -> kb_out %0d", bus.kb_out);
        check("async reset kb_out", int'(bus.kb_out), 0);
        check("async reset frame_err", int'(bus.frame_err), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int b = 4; b < 11; b++) send_bit(rbits[b]);
        repeat (T + 50) @(negedge clk);
        check("after reset garbage kb_out", int'(bus.kb_out), 0);
        send_frame(8'h16, 0, 0);
        $display("[TB] after reset 16 -> kb_out %0d", bus.kb_out);
        check("post-reset 16", int'(bus.kb_out), 49);

        check("frame_err max width", max_run, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
